// File: rtl/sar_multiplier_module.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock,
// early exit once the remaining multiplier bits are zero.
module sar_multiplier_module #(
  parameter int unsigned BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BITS-1:0]     multiplicando,
  input  logic [BITS-1:0]     multiplicador,
  output logic [2*BITS-1:0]   product,
  output logic [BITS-1:0]     result,
  output logic                overflow,
  output logic                busy,
  output logic                ready
);

  localparam int unsigned PW = 2 * BITS;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [BITS-1:0] mult_q, mult_d;
  logic [PW-1:0]   product_q, product_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;

  logic [PW-1:0]   sum;
  logic [BITS-1:0] mult_shr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mult_q     <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mult_q     <= mult_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mult_d     = mult_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    sum        = product_q + (mult_q[0] ? acc_q : PW'(0));
    mult_shr   = mult_q >> 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = PW'(multiplicando);
          // A zero multiplicand makes every partial sum zero; skip the walk.
          mult_d     = (multiplicando == '0) ? '0 : multiplicador;
          product_d  = '0;
          overflow_d = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        product_d = sum;
        acc_d     = acc_q << 1;
        mult_d    = mult_shr;
        if (mult_shr == '0) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          ready_d    = 1'b1;
          overflow_d = |sum[PW-1:BITS];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign product  = product_q;
  assign result   = product_q[BITS-1:0];
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_sar_multiplier_module.sv
// Bench for sar_multiplier_module: directed table, handshake corner cases and
// randomized operands against an arithmetic reference model.
module tb_sar_multiplier_module;

  localparam int unsigned BITS = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [BITS-1:0]   a_in, b_in;
  logic [2*BITS-1:0] product;
  logic [BITS-1:0]   result;
  logic              overflow, busy, ready;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic [2*BITS-1:0] prod;
    int                lat;
  } vec_t;

  vec_t vecs[5];

  sar_multiplier_module #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicando(a_in), .multiplicador(b_in),
    .product(product), .result(result), .overflow(overflow),
    .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: plain multiplication and bit-length of the multiplier.
  function automatic logic [2*BITS-1:0] ref_prod(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    return (2*BITS)'(a) * (2*BITS)'(b);
  endfunction

  function automatic int ref_lat(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    int n = 0;
    logic [BITS-1:0] t = b;
    if (a == 0 || b == 0) return 1;
    while (t != 0) begin n++; t = t >> 1; end
    return n;
  endfunction

  // Drive a start with given operands and check the accept edge.
  task automatic accept(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_ready", 64'(ready), 64'd0);
    chk("accept_product", 64'(product), 64'd0);
    start = 1'b0;
    a_in = BITS'($urandom); b_in = BITS'($urandom);
  endtask

  // Count edges until busy drops, then check latency and the result.
  task automatic wait_done(input string name, input logic [2*BITS-1:0] exp, input int lat);
    int cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy) break;
    end
    chk({name, "_lat"}, 64'(cyc), 64'(lat));
    chk({name, "_ready"}, 64'(ready), 64'd1);
    chk({name, "_product"}, 64'(product), 64'(exp));
    chk({name, "_result"}, 64'(result), 64'(exp[BITS-1:0]));
    chk({name, "_ovf"}, 64'(overflow), 64'(exp[2*BITS-1:BITS] != 0));
  endtask

  initial begin
    vecs[0] = '{16'd7,    16'd6,    32'd42,         3};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001,  16};
    vecs[2] = '{16'd5,    16'd0,    32'd0,          1};
    vecs[3] = '{16'd0,    16'h8000, 32'd0,          1};
    vecs[4] = '{16'd1,    16'h8000, 32'h00008000,  16};

    reset = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].prod, vecs[i].lat);
    end

    // Idle hold: results persist while start stays low.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_ready", 64'(ready), 64'd1);
    chk("hold_product", 64'(product), 64'h8000);

    // Start while busy is ignored.
    accept(16'd1234, 16'd37);
    @(posedge clk); #1;
    a_in = 16'd9; b_in = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ignore_busy", 64'(busy), 64'd1);
    begin
      int cyc = 2;
      while (cyc < 40 && busy) begin @(posedge clk); #1; cyc++; end
      chk("busy_ignore_lat", 64'(cyc), 64'd6);
    end
    chk("busy_ignore_product", 64'(product), 64'd45658);
    chk("busy_ignore_ovf", 64'(overflow), 64'd0);
    accept(16'd9, 16'd9);
    wait_done("after_ignore", 32'd81, 4);

    // Asynchronous reset mid-run; start held through release is not taken early.
    accept(16'd300, 16'd300);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_product", 64'(product), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    a_in = 16'd3; b_in = 16'd3; start = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("release_no_accept", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("release_accept", 64'(busy), 64'd1);
    start = 1'b0; a_in = BITS'($urandom); b_in = BITS'($urandom);
    wait_done("after_rst", 32'd9, 2);

    // Back-to-back with start held high.
    a_in = 16'd2; b_in = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    a_in = 16'd4; b_in = 16'd5;
    @(posedge clk); #1;
    chk("b2b_mid_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("b2b_first_ready", 64'(ready), 64'd1);
    chk("b2b_first_product", 64'(product), 64'd6);
    @(posedge clk); #1;
    chk("b2b_restart_busy", 64'(busy), 64'd1);
    chk("b2b_restart_ready", 64'(ready), 64'd0);
    start = 1'b0;
    wait_done("b2b_second", 32'd20, 3);

    // Randomized operands with varied multiplier bit-lengths.
    for (int i = 0; i < 40; i++) begin
      logic [BITS-1:0] ra, rb;
      int w;
      ra = BITS'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '0;
      w  = $urandom_range(0, BITS);
      rb = (w == 0) ? '0 : BITS'($urandom) & BITS'((32'd1 << w) - 1);
      accept(ra, rb);
      wait_done($sformatf("rand%0d", i), ref_prod(ra, rb), ref_lat(ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
